// File: rtl/hood_mode_if.sv
// hood_mode_if: button/fan-mode bundle between the debounced front panel and
// hood_mode_ctrl.
//   master (front panel / bench): drives power_on and the one-cycle pulses,
//                                 observes mode, LEDs, timer and status.
//   slave  (hood_mode_ctrl):      the reverse.
// Handshake: there is no valid/ready pair. Every *_pulse is a one-cycle strobe
// that is sampled on the rising clk edge where it is high. It is consumed on
// that edge or dropped; it is never held or queued. All outputs are registered
// and change only on rising clk edges.
// SEC_W must match the SEC_W that the attached hood_mode_ctrl derives.
interface hood_mode_if #(
  parameter int SEC_W = 8
);
  logic             power_on;
  logic             menu_pulse;
  logic             l1_pulse;
  logic             l2_pulse;
  logic             l3_pulse;
  logic             clean_pulse;
  logic [2:0]       mode;
  logic             menu_armed;
  logic [4:0]       led;
  logic [SEC_W-1:0] remaining_s;
  logic             turbo_used;
  logic             clean_done;
  logic [2:0]       state_dbg;   // raw controller state, for checkers

  modport master (
    output power_on, menu_pulse, l1_pulse, l2_pulse, l3_pulse, clean_pulse,
    input  mode, menu_armed, led, remaining_s, turbo_used, clean_done, state_dbg
  );

  modport slave (
    input  power_on, menu_pulse, l1_pulse, l2_pulse, l3_pulse, clean_pulse,
    output mode, menu_armed, led, remaining_s, turbo_used, clean_done, state_dbg
  );
endinterface

// File: rtl/hood_mode_ctrl.sv
// hood_mode_ctrl: fan-mode controller for the range hood.
// Ports:
//   clk  - system clock
//   rst  - asynchronous, active-low reset
//   bus  - hood_mode_if.slave:
//          in : power_on, menu_pulse, l1/l2/l3/clean_pulse
//          out: mode, menu_armed, led {clean,L3,L2,L1,standby},
//               remaining_s, turbo_used, clean_done, state_dbg
// Timed states (L3, L3_RET, CLEAN) count whole seconds with a prescaler.
// A timed state loaded with N seconds lasts exactly N*CLK_HZ cycles.
// Level 3 may be entered once per power session.
module hood_mode_ctrl #(
  parameter int CLK_HZ   = 100_000_000,
  parameter int TURBO_S  = 60,
  parameter int RETURN_S = 60,
  parameter int CLEAN_S  = 180,
  parameter int SEC_W    = $clog2(((TURBO_S > RETURN_S ? TURBO_S : RETURN_S) > CLEAN_S ?
                                   (TURBO_S > RETURN_S ? TURBO_S : RETURN_S) : CLEAN_S) + 1)
) (
  input logic       clk,
  input logic       rst,
  hood_mode_if.slave bus
);

  localparam int PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_HZ - 1);

  typedef enum logic [2:0] {
    ST_STANDBY = 3'd0,
    ST_L1      = 3'd1,
    ST_L2      = 3'd2,
    ST_L3      = 3'd3,
    ST_L3_RET  = 3'd4,
    ST_CLEAN   = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic             armed_q, armed_d;
  logic             turbo_q, turbo_d;
  logic [SEC_W-1:0] rem_q, rem_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             clean_done_q, clean_done_d;
  logic [2:0]       mode_q, mode_d;
  logic [4:0]       led_q, led_d;

  logic             timed;
  logic             sec_tick;
  logic             expire;
  logic             load;
  logic [SEC_W-1:0] load_val;

  always_comb begin
    state_d      = state_q;
    armed_d      = armed_q;
    turbo_d      = turbo_q;
    rem_d        = rem_q;
    pre_d        = '0;        // prescaler parks at 0 outside timed states
    clean_done_d = 1'b0;
    load         = 1'b0;
    load_val     = '0;
    mode_d       = 3'b000;
    led_d        = 5'b00000;

    timed    = (state_q == ST_L3) || (state_q == ST_L3_RET) || (state_q == ST_CLEAN);
    sec_tick = timed && (pre_q == PRE_LAST);
    // Expiry is the final tick itself, so it wins over any button this cycle.
    expire   = sec_tick && (rem_q == SEC_W'(1));

    if (timed) begin
      pre_d = sec_tick ? '0 : pre_q + PRE_W'(1);
      if (sec_tick && (rem_q != '0)) rem_d = rem_q - SEC_W'(1);
    end

    if (!bus.power_on) begin
      state_d = ST_STANDBY;
      armed_d = 1'b0;
      turbo_d = 1'b0;
      rem_d   = '0;
      pre_d   = '0;
    end else begin
      unique case (state_q)
        ST_STANDBY: begin
          // A menu press only toggles the arm; a same-cycle selection is dropped.
          if (bus.menu_pulse) begin
            armed_d = !armed_q;
          end else if (armed_q) begin
            if (bus.l1_pulse) begin
              state_d = ST_L1;
              armed_d = 1'b0;
            end else if (bus.l2_pulse) begin
              state_d = ST_L2;
              armed_d = 1'b0;
            end else if (bus.l3_pulse && !turbo_q) begin
              state_d  = ST_L3;
              armed_d  = 1'b0;
              turbo_d  = 1'b1;
              load     = 1'b1;
              load_val = SEC_W'(TURBO_S);
            end else if (bus.clean_pulse) begin
              state_d  = ST_CLEAN;
              armed_d  = 1'b0;
              load     = 1'b1;
              load_val = SEC_W'(CLEAN_S);
            end
          end
        end
        ST_L1: begin
          if (bus.menu_pulse) begin
            state_d = ST_STANDBY;
            armed_d = 1'b0;
          end else if (bus.l2_pulse) begin
            state_d = ST_L2;
          end
        end
        ST_L2: begin
          if (bus.menu_pulse) begin
            state_d = ST_STANDBY;
            armed_d = 1'b0;
          end else if (bus.l1_pulse) begin
            state_d = ST_L1;
          end
        end
        ST_L3: begin
          if (expire) begin
            state_d = ST_L2;   // rem_d has already decremented to 0
          end else if (bus.menu_pulse) begin
            state_d  = ST_L3_RET;
            load     = 1'b1;
            load_val = SEC_W'(RETURN_S);
          end
        end
        ST_L3_RET: begin
          if (expire) state_d = ST_STANDBY;
        end
        ST_CLEAN: begin
          if (expire) begin
            state_d      = ST_STANDBY;
            clean_done_d = 1'b1;
          end
        end
        default: begin
          state_d = ST_STANDBY;
          armed_d = 1'b0;
          rem_d   = '0;
        end
      endcase
    end

    // A fresh load restarts the second from its beginning.
    if (load) begin
      rem_d = load_val;
      pre_d = '0;
    end

    unique case (state_d)
      ST_L1:     mode_d = 3'b001;
      ST_L2:     mode_d = 3'b010;
      ST_L3:     mode_d = 3'b011;
      ST_L3_RET: mode_d = 3'b011;
      ST_CLEAN:  mode_d = 3'b100;
      default:   mode_d = 3'b000;
    endcase

    if (bus.power_on) begin
      unique case (state_d)
        ST_L1:     led_d = 5'b00010;
        ST_L2:     led_d = 5'b00100;
        ST_L3:     led_d = 5'b01000;
        ST_L3_RET: led_d = 5'b01000;
        ST_CLEAN:  led_d = 5'b10000;
        default:   led_d = 5'b00001;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_STANDBY;
      armed_q      <= 1'b0;
      turbo_q      <= 1'b0;
      rem_q        <= '0;
      pre_q        <= '0;
      clean_done_q <= 1'b0;
      mode_q       <= 3'b000;
      led_q        <= 5'b00001;
    end else begin
      state_q      <= state_d;
      armed_q      <= armed_d;
      turbo_q      <= turbo_d;
      rem_q        <= rem_d;
      pre_q        <= pre_d;
      clean_done_q <= clean_done_d;
      mode_q       <= mode_d;
      led_q        <= led_d;
    end
  end

  assign bus.mode        = mode_q;
  assign bus.menu_armed  = armed_q;
  assign bus.led         = led_q;
  assign bus.remaining_s = rem_q;
  assign bus.turbo_used  = turbo_q;
  assign bus.clean_done  = clean_done_q;
  assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_hood_mode_ctrl.sv
// tb_hood_mode_ctrl: directed checks of hood_mode_ctrl with CLK_HZ=10,
// TURBO_S=3, RETURN_S=2, CLEAN_S=4 (SEC_W=3).
module tb_hood_mode_ctrl;

  localparam int SEC_W = 3;

  // button mask bits for press()
  localparam int B_MENU  = 1;
  localparam int B_L1    = 2;
  localparam int B_L2    = 4;
  localparam int B_L3    = 8;
  localparam int B_CLEAN = 16;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  hood_mode_if #(.SEC_W(SEC_W)) bus();

  hood_mode_ctrl #(
    .CLK_HZ  (10),
    .TURBO_S (3),
    .RETURN_S(2),
    .CLEAN_S (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // driver tasks: inputs change and outputs are sampled 1 time unit after posedge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press(input int mask);
    bus.menu_pulse  = (mask & B_MENU)  != 0;
    bus.l1_pulse    = (mask & B_L1)    != 0;
    bus.l2_pulse    = (mask & B_L2)    != 0;
    bus.l3_pulse    = (mask & B_L3)    != 0;
    bus.clean_pulse = (mask & B_CLEAN) != 0;
    tick();
    bus.menu_pulse  = 1'b0;
    bus.l1_pulse    = 1'b0;
    bus.l2_pulse    = 1'b0;
    bus.l3_pulse    = 1'b0;
    bus.clean_pulse = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b0;
    bus.power_on    = 1'b1;
    bus.menu_pulse  = 1'b0;
    bus.l1_pulse    = 1'b0;
    bus.l2_pulse    = 1'b0;
    bus.l3_pulse    = 1'b0;
    bus.clean_pulse = 1'b0;

    // reset
    ticks(2);
    chk("rst_led",   32'(bus.led), 'b00001);
    chk("rst_mode",  32'(bus.mode), 0);
    chk("rst_rem",   32'(bus.remaining_s), 0);
    chk("rst_armed", 32'(bus.menu_armed), 0);
    chk("rst_turbo", 32'(bus.turbo_used), 0);
    chk("rst_cdone", 32'(bus.clean_done), 0);
    rst = 1'b1;
    tick();
    chk("pwr_led",  32'(bus.led), 'b00001);
    chk("pwr_mode", 32'(bus.mode), 0);

    // menu + l2
    press(B_MENU);
    chk("arm", 32'(bus.menu_armed), 1);
    press(B_L2);
    chk("l2_mode",  32'(bus.mode), 'b010);
    chk("l2_led",   32'(bus.led), 'b00100);
    chk("l2_armed", 32'(bus.menu_armed), 0);
    press(B_MENU);
    chk("l2_menu_mode", 32'(bus.mode), 0);
    chk("l2_menu_led",  32'(bus.led), 'b00001);

    // unarmed menu with selection: only arm toggles
    press(B_MENU | B_L1);
    chk("menu_sel_armed", 32'(bus.menu_armed), 1);
    chk("menu_sel_mode",  32'(bus.mode), 0);
    press(B_MENU);
    chk("disarm", 32'(bus.menu_armed), 0);

    // L1/L2 moves, ignored l3, menu beats level pulse
    press(B_MENU);
    press(B_L1);
    chk("l1_mode", 32'(bus.mode), 'b001);
    chk("l1_led",  32'(bus.led), 'b00010);
    press(B_L2);
    chk("l1_to_l2", 32'(bus.mode), 'b010);
    press(B_L1);
    chk("l2_to_l1", 32'(bus.mode), 'b001);
    press(B_L3);
    chk("l1_l3_ign", 32'(bus.mode), 'b001);
    press(B_MENU | B_L2);
    chk("menu_prio_mode", 32'(bus.mode), 0);

    // turbo with fallback; menu on expiry edge is dropped
    press(B_MENU);
    press(B_L3);
    chk("l3_mode",  32'(bus.mode), 'b011);
    chk("l3_rem",   32'(bus.remaining_s), 3);
    chk("l3_turbo", 32'(bus.turbo_used), 1);
    chk("l3_led",   32'(bus.led), 'b01000);
    ticks(19);
    chk("l3_rem_19", 32'(bus.remaining_s), 2);
    tick();
    chk("l3_rem_20", 32'(bus.remaining_s), 1);
    ticks(9);
    chk("l3_mode_29", 32'(bus.mode), 'b011);
    press(B_MENU);
    chk("l3_exp_mode", 32'(bus.mode), 'b010);
    chk("l3_exp_rem",  32'(bus.remaining_s), 0);
    chk("l3_exp_led",  32'(bus.led), 'b00100);
    press(B_MENU);
    chk("back_standby", 32'(bus.mode), 0);

    // turbo already used
    press(B_MENU);
    press(B_L3);
    chk("turbo_blk_mode",  32'(bus.mode), 0);
    chk("turbo_blk_armed", 32'(bus.menu_armed), 1);

    // power cycle restores turbo
    bus.power_on = 1'b0;
    tick();
    chk("off_led",   32'(bus.led), 0);
    chk("off_armed", 32'(bus.menu_armed), 0);
    chk("off_turbo", 32'(bus.turbo_used), 0);
    bus.power_on = 1'b1;
    tick();
    chk("on_led", 32'(bus.led), 'b00001);
    press(B_MENU);
    press(B_L3);
    chk("l3b_mode", 32'(bus.mode), 'b011);
    chk("l3b_rem",  32'(bus.remaining_s), 3);

    // run-down entered at cycle 5
    ticks(4);
    press(B_MENU);
    chk("ret_mode", 32'(bus.mode), 'b011);
    chk("ret_rem",  32'(bus.remaining_s), 2);
    chk("ret_led",  32'(bus.led), 'b01000);
    ticks(9);
    press(B_L1);
    chk("ret_l1_ign", 32'(bus.mode), 'b011);
    chk("ret_rem_10", 32'(bus.remaining_s), 1);
    ticks(9);
    chk("ret_mode_19", 32'(bus.mode), 'b011);
    tick();
    chk("ret_exp_mode", 32'(bus.mode), 0);
    chk("ret_exp_led",  32'(bus.led), 'b00001);
    chk("ret_exp_rem",  32'(bus.remaining_s), 0);

    // self-clean to completion
    press(B_MENU);
    press(B_CLEAN);
    chk("cl_led",  32'(bus.led), 'b10000);
    chk("cl_mode", 32'(bus.mode), 'b100);
    chk("cl_rem",  32'(bus.remaining_s), 4);
    ticks(4);
    press(B_L1);
    chk("cl_l1_ign", 32'(bus.mode), 'b100);
    press(B_MENU);
    chk("cl_menu_ign",   32'(bus.mode), 'b100);
    chk("cl_menu_armed", 32'(bus.menu_armed), 0);
    ticks(33);
    chk("cl_mode_39",  32'(bus.mode), 'b100);
    chk("cl_rem_39",   32'(bus.remaining_s), 1);
    chk("cl_cdone_39", 32'(bus.clean_done), 0);
    tick();
    chk("cl_exp_mode",  32'(bus.mode), 0);
    chk("cl_exp_cdone", 32'(bus.clean_done), 1);
    chk("cl_exp_led",   32'(bus.led), 'b00001);
    tick();
    chk("cl_cdone_41", 32'(bus.clean_done), 0);

    // power loss mid-clean
    press(B_MENU);
    press(B_CLEAN);
    ticks(20);
    chk("cl2_rem_20", 32'(bus.remaining_s), 2);
    bus.power_on = 1'b0;
    tick();
    chk("cl2_off_led",  32'(bus.led), 0);
    chk("cl2_off_rem",  32'(bus.remaining_s), 0);
    chk("cl2_off_mode", 32'(bus.mode), 0);
    bus.power_on = 1'b1;
    tick();
    chk("cl2_on_led",   32'(bus.led), 'b00001);
    chk("cl2_on_cdone", 32'(bus.clean_done), 0);
    ticks(30);
    chk("cl2_late_cdone", 32'(bus.clean_done), 0);
    chk("cl2_late_mode",  32'(bus.mode), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hood_mode_ctrl.md
# hood_mode_ctrl

Parametrised fan-mode controller for the range-hood design. It sits between the debounced button pulses and the fan driver, LED bank and display logic, and replaces the fixed-constant mode FSM. The controller adds configurable clock rate and durations, automatic turbo-to-level-2 fallback, a timed return-to-standby from turbo, one turbo use per power session, and a live seconds-remaining output.

## Interface
Parameters:
- CLK_HZ, 100_000_000: clk cycles per second; prescaler terminal count.
- TURBO_S, 60: seconds in level 3 before automatic drop to level 2.
- RETURN_S, 60: seconds of level-3 run-down after menu is pressed in level 3; the block then goes to standby.
- CLEAN_S, 180: seconds of self-clean.
- SEC_W, derived: $clog2(max(TURBO_S,RETURN_S,CLEAN_S)+1); width of the seconds counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- power_on  in  1  level; machine powered.
- menu_pulse  in  1  one-cycle debounced menu press.
- l1_pulse, l2_pulse, l3_pulse, clean_pulse  in  1 each  one-cycle debounced selection presses.
- mode  out  3  000 standby/off, 001 L1, 010 L2, 011 L3 (incl. run-down), 100 clean.
- menu_armed  out  1  menu toggled and awaiting a selection.
- led  out  5  {clean, L3, L2, L1, standby}, one-hot; all zero when off.
- remaining_s  out  SEC_W  seconds left in a timed state; 0 otherwise.
- turbo_used  out  1  level 3 already entered this power session.
- clean_done  out  1  one-cycle pulse on self-clean completion.

## Operation
- Internal states: STANDBY, L1, L2, L3, L3_RET, CLEAN. All outputs are registered.
- power_on low: state STANDBY, led 00000, menu_armed 0, turbo_used 0, timers cleared. This condition overrides every other event.
- STANDBY (powered): led 00001. menu_pulse toggles menu_armed.
  - While armed, the priority order is l1 > l2 > l3 > clean. The chosen selection enters its state and clears menu_armed.
  - l3_pulse is ignored when turbo_used=1; menu_armed stays 1 in that case.
- L1/L2:
  - l2_pulse in L1 goes to L2; l1_pulse in L2 goes to L1.
  - menu_pulse goes to STANDBY with menu_armed 0. menu_pulse has priority over a same-cycle level pulse.
  - l3_pulse and clean_pulse are ignored.
- L3: entry sets turbo_used=1 and loads remaining_s=TURBO_S.
  - On expiry, go to L2 (remaining_s 0, led 00100).
  - menu_pulse goes to L3_RET and loads RETURN_S.
- L3_RET: mode 011, led 01000. On expiry, go to STANDBY. All buttons are ignored.
- CLEAN: loads CLEAN_S. All buttons are ignored. On expiry, go to STANDBY and clean_done=1 for one cycle.
- Timer:
  - Prescaler runs 0..CLK_HZ-1; sec_tick is asserted when it equals CLK_HZ-1.
  - On every load, the prescaler resets to 0.
  - Each sec_tick decrements remaining_s.
  - Expiry occurs when sec_tick and remaining_s==1 coincide, so each timed state lasts exactly N*CLK_HZ cycles.
  - The prescaler is held at 0 in untimed states.

## Timing
- Reset: mode 000, led 00001, menu_armed 0, remaining_s 0, turbo_used 0, clean_done 0, prescaler 0, state STANDBY. After reset, led follows power_on on the first edge.
- Pulse to output latency is one clk: outputs change on the edge that samples the pulse.
- Expiry takes effect on the same edge as the final sec_tick.
- Expiry and a button on the same cycle: expiry wins and the button is dropped.
- menu_pulse in unarmed STANDBY together with a selection: only menu_armed toggles; the selection is ignored.
- power_on falling mid-countdown: the countdown is abandoned, and re-power starts in STANDBY with turbo available.
- remaining_s never underflows. It holds 0 outside L3/L3_RET/CLEAN.

## Test plan
All scenarios use CLK_HZ=10, TURBO_S=3, RETURN_S=2, CLEAN_S=4.
- Reset low then high with power_on=1: led=00001, mode=000. Then menu, l2: mode=010, led=00100, menu_armed=0 one cycle after l2.
- Armed standby, l3: mode=011 and remaining_s=3. It reaches 1 after 20 cycles, and at cycle 30 mode=010, remaining_s=0.
- In L3 at cycle 5, menu: mode stays 011 and remaining_s=2. 20 cycles later mode=000, led=00001.
- After one turbo use, menu then l3 is ignored (mode 000, armed 1). Toggling power_on 0 then 1, then menu and l3: mode=011.
- Armed standby, clean: led=10000. Presses of l1/menu during clean do nothing. At cycle 40 mode=000 with clean_done high exactly one cycle.
- In CLEAN with remaining_s=2, drop power_on: led=00000, remaining_s=0 next edge. Re-power: led=00001, no clean_done.
